// File: rtl/bus_err_drain.sv
// Drains the bus error unit's FIFO one entry per take, holds it as a record on a
// valid/ready stream, and keeps a saturating error count, sticky code mask and overflow flag.
module bus_err_drain #(
    parameter int AddrWidth     = 48,
    parameter int MetaDataWidth = 1,
    parameter int ErrBits       = 3,
    parameter int CntWidth      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      err_irq_i,
    input  logic [ErrBits-1:0]        err_code_i,
    input  logic [AddrWidth-1:0]      err_addr_i,
    input  logic [MetaDataWidth-1:0]  err_meta_i,
    output logic                      err_fifo_pop_o,
    output logic                      rec_valid_o,
    input  logic                      rec_ready_i,
    output logic [ErrBits-1:0]        rec_code_o,
    output logic [AddrWidth-1:0]      rec_addr_o,
    output logic [MetaDataWidth-1:0]  rec_meta_o,
    output logic [CntWidth-1:0]       err_count_o,
    output logic [(2**ErrBits)-1:0]   code_seen_o,
    output logic                      overflow_o,
    input  logic                      cnt_clear_i,
    output logic                      busy_o
);

    localparam int NumCodes = 2 ** ErrBits;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic                       take_s;
    logic                       rec_valid_r;
    logic                       busy_r;
    logic [ErrBits-1:0]         rec_code_r;
    logic [AddrWidth-1:0]       rec_addr_r;
    logic [MetaDataWidth-1:0]   rec_meta_r;
    logic [CntWidth-1:0]        err_count_r;
    logic [NumCodes-1:0]        code_seen_r;
    logic                       overflow_r;

    function automatic logic [NumCodes-1:0] code_onehot(input logic [ErrBits-1:0] code);
        logic [NumCodes-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

    // Pop decision: the slot is free when idle or when the held record leaves this cycle.
    // Reset gates it so a pending irq during reset never pops.
    always_comb begin
        take_s = 1'b0;
        if (!rst_i && enable_i && err_irq_i) begin
            take_s = (state_r == ST_IDLE) || ((state_r == ST_SEND) && rec_ready_i);
        end else begin
            take_s = 1'b0;
        end
    end

    // Next-state logic for the record holder.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (rec_ready_i) begin
                    state_next_s = take_s ? ST_SEND : ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with registered valid/busy mirrors of the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            rec_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rec_valid_r <= (state_next_s == ST_SEND);
            busy_r      <= (state_next_s == ST_SEND);
        end
    end

    // Record capture from the FIFO head on every take.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rec_code_r <= '0;
            rec_addr_r <= '0;
            rec_meta_r <= '0;
        end else if (take_s) begin
            rec_code_r <= err_code_i;
            rec_addr_r <= err_addr_i;
            rec_meta_r <= err_meta_i;
        end
    end

    // Statistics: clear wins over a same-cycle take, which is then neither counted nor marked.
    always_ff @(posedge clk_i) begin
        if (rst_i || cnt_clear_i) begin
            err_count_r <= '0;
            code_seen_r <= '0;
            overflow_r  <= 1'b0;
        end else if (take_s) begin
            code_seen_r <= code_seen_r | code_onehot(err_code_i);
            if (err_count_r == {CntWidth{1'b1}}) begin
                overflow_r <= 1'b1;
            end else begin
                err_count_r <= err_count_r + CntWidth'(1);
            end
        end
    end

    assign err_fifo_pop_o = take_s;
    assign rec_valid_o    = rec_valid_r;
    assign busy_o         = busy_r;
    assign rec_code_o     = rec_code_r;
    assign rec_addr_o     = rec_addr_r;
    assign rec_meta_o     = rec_meta_r;
    assign err_count_o    = err_count_r;
    assign code_seen_o    = code_seen_r;
    assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_bus_err_drain.sv
// Bench for bus_err_drain: a queue-based FIFO and record model drives directed
// scenarios followed by randomized traffic, checked every cycle.
module tb_bus_err_drain;

    localparam int AW = 48;
    localparam int MW = 1;
    localparam int EB = 3;
    localparam int CW = 2;
    localparam int CNT_MAX = (2 ** CW) - 1;

    typedef struct packed {
        logic [EB-1:0] code;
        logic [AW-1:0] addr;
        logic [MW-1:0] meta;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              enable_i = 1'b1;
    logic              err_irq_i = 1'b0;
    logic [EB-1:0]     err_code_i = '0;
    logic [AW-1:0]     err_addr_i = '0;
    logic [MW-1:0]     err_meta_i = '0;
    logic              err_fifo_pop_o;
    logic              rec_valid_o;
    logic              rec_ready_i = 1'b1;
    logic [EB-1:0]     rec_code_o;
    logic [AW-1:0]     rec_addr_o;
    logic [MW-1:0]     rec_meta_o;
    logic [CW-1:0]     err_count_o;
    logic [(2**EB)-1:0] code_seen_o;
    logic              overflow_o;
    logic              cnt_clear_i = 1'b0;
    logic              busy_o;

    bus_err_drain #(.AddrWidth(AW), .MetaDataWidth(MW), .ErrBits(EB), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .err_irq_i(err_irq_i),
        .err_code_i(err_code_i), .err_addr_i(err_addr_i), .err_meta_i(err_meta_i),
        .err_fifo_pop_o(err_fifo_pop_o), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_code_o(rec_code_o), .rec_addr_o(rec_addr_o), .rec_meta_o(rec_meta_o),
        .err_count_o(err_count_o), .code_seen_o(code_seen_o), .overflow_o(overflow_o),
        .cnt_clear_i(cnt_clear_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference model state: FIFO contents, the held record, and pops counted since clear.
    entry_t  fifo_q[$];
    entry_t  m_rec;
    bit      m_hold = 1'b0;
    int      m_pops = 0;
    logic [(2**EB)-1:0] m_seen = '0;
    int      checks = 0;
    int      fails = 0;
    int      pops_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [EB-1:0] c, input logic [AW-1:0] a, input logic [MW-1:0] m);
        entry_t e;
        e.code = c; e.addr = a; e.meta = m;
        fifo_q.push_back(e);
    endtask

    // One clock: present the FIFO head, check outputs, then advance the model at the edge.
    task automatic cycle();
        bit pop_exp;
        bit hs;
        err_irq_i = (fifo_q.size() != 0);
        if (err_irq_i) begin
            err_code_i = fifo_q[0].code;
            err_addr_i = fifo_q[0].addr;
            err_meta_i = fifo_q[0].meta;
        end else begin
            err_code_i = EB'($urandom);
            err_addr_i = {$urandom, $urandom};
            err_meta_i = MW'($urandom);
        end
        pop_exp = !rst_i && enable_i && err_irq_i && (!m_hold || rec_ready_i);
        #1;
        chk("pop", 64'(err_fifo_pop_o), 64'(pop_exp));
        chk("valid", 64'(rec_valid_o), 64'(m_hold));
        chk("busy", 64'(busy_o), 64'(m_hold));
        chk("count", 64'(err_count_o), 64'((m_pops > CNT_MAX) ? CNT_MAX : m_pops));
        chk("overflow", 64'(overflow_o), 64'(m_pops > CNT_MAX));
        chk("seen", 64'(code_seen_o), 64'(m_seen));
        if (m_hold) begin
            chk("rec_code", 64'(rec_code_o), 64'(m_rec.code));
            chk("rec_addr", 64'(rec_addr_o), 64'(m_rec.addr));
            chk("rec_meta", 64'(rec_meta_o), 64'(m_rec.meta));
        end
        @(posedge clk);
        if (rst_i) begin
            m_hold = 1'b0;
            m_pops = 0;
            m_seen = '0;
        end else begin
            hs = m_hold && rec_ready_i;
            if (pop_exp) begin
                m_rec  = fifo_q.pop_front();
                m_hold = 1'b1;
                pops_seen++;
                if (!cnt_clear_i) begin
                    m_pops++;
                    m_seen[m_rec.code] = 1'b1;
                end
            end else if (hs) begin
                m_hold = 1'b0;
            end
            if (cnt_clear_i) begin
                m_pops = 0;
                m_seen = '0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int start_pops;
        // Reset with an entry already pending: no pop while reset is held.
        push(3'd5, 48'h0000_0000_2222, 1'b1);
        @(negedge clk);
        repeat (2) cycle();
        chk("reset_count", 64'(err_count_o), 64'd0);
        fifo_q.delete();
        rst_i = 1'b0;
        cycle();

        // Single entry, sink ready.
        push(3'd3, 48'h0000_0000_1000, 1'b0);
        cycle();
        cycle();
        chk("single_count", 64'(err_count_o), 64'd1);
        chk("single_seen", 64'(code_seen_o), 64'h08);
        cycle();

        // Four back-to-back entries at full throughput.
        for (int i = 0; i < 4; i++) push(EB'(i), 48'h0000_0000_A000 + AW'(i), MW'(i));
        start_pops = pops_seen;
        repeat (6) cycle();
        chk("burst_pops", 64'(pops_seen - start_pops), 64'd4);

        // Back-pressure: two queued, sink stalled for five cycles.
        rst_i = 1'b1; cycle(); rst_i = 1'b0;
        push(3'd6, 48'h0000_0000_B000, 1'b1);
        push(3'd7, 48'h0000_0000_B004, 1'b0);
        rec_ready_i = 1'b0;
        start_pops = pops_seen;
        repeat (5) cycle();
        chk("stall_pops", 64'(pops_seen - start_pops), 64'd1);
        rec_ready_i = 1'b1;
        repeat (3) cycle();

        // Saturation then clear coinciding with a take.
        for (int i = 0; i < 5; i++) push(EB'(i + 1), 48'h0000_0000_C000 + AW'(i), 1'b0);
        repeat (6) cycle();
        chk("sat_count", 64'(err_count_o), 64'd3);
        chk("sat_ovf", 64'(overflow_o), 64'd1);
        push(3'd2, 48'h0000_0000_D000, 1'b1);
        cnt_clear_i = 1'b1;
        cycle();
        cnt_clear_i = 1'b0;
        chk("clr_count", 64'(err_count_o), 64'd0);
        chk("clr_ovf", 64'(overflow_o), 64'd0);
        repeat (2) cycle();

        // Disabled drain, then reset while a record is held.
        push(3'd4, 48'h0000_0000_E000, 1'b0);
        enable_i = 1'b0;
        repeat (3) cycle();
        enable_i = 1'b1;
        rec_ready_i = 1'b0;
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("rst_send_valid", 64'(rec_valid_o), 64'd0);
        rec_ready_i = 1'b1;
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if (($urandom_range(0, 2) != 0) && (fifo_q.size() < 8))
                push(EB'($urandom), {$urandom, $urandom}, MW'($urandom));
            enable_i    = ($urandom_range(0, 9) != 0);
            rec_ready_i = ($urandom_range(0, 9) < 7);
            cnt_clear_i = ($urandom_range(0, 19) == 0);
            rst_i       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        enable_i = 1'b1; rec_ready_i = 1'b1; cnt_clear_i = 1'b0; rst_i = 1'b0;
        for (int n = 0; n < 50 && (fifo_q.size() != 0 || m_hold); n++) cycle();
        chk("drain_empty", 64'(fifo_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
